// File: rtl/apb_master_arbiter_pkg.sv
// ============================================================================
// apb_master_arbiter_pkg : state encodings, default widths and helpers
// Revision: 1.0
// ============================================================================
`default_nettype none

package apb_master_arbiter_pkg;

  localparam int c_DEF_NUM_MST = 2;
  localparam int c_DEF_NUM_SLV = 4;
  localparam int c_DEF_AW      = 16;
  localparam int c_DEF_DW      = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  function automatic int unsigned rr_next(input int unsigned cur, input int unsigned n);
    return (cur + 1 >= n) ? 0 : cur + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/apb_master_arbiter_if.sv
// ============================================================================
// apb_master_arbiter_if : upstream master buses and shared slave-side bus
// Revision: 1.0
// ============================================================================
`default_nettype none

interface apb_master_arbiter_if
  import apb_master_arbiter_pkg::*;
#(
  parameter int NUM_MST = c_DEF_NUM_MST,
  parameter int NUM_SLV = c_DEF_NUM_SLV,
  parameter int AW      = c_DEF_AW,
  parameter int DW      = c_DEF_DW
);
  logic [NUM_MST*NUM_SLV-1:0] iPSEL;
  logic [NUM_MST-1:0]         iPENABLE;
  logic [NUM_MST-1:0]         iPWRITE;
  logic [NUM_MST*AW-1:0]      iPADDR;
  logic [NUM_MST*DW-1:0]      iPWDATA;
  logic [DW-1:0]              oPRDATA;
  logic [NUM_MST-1:0]         oPREADY;
  logic [NUM_SLV-1:0]         oPSEL;
  logic                       oPENABLE;
  logic                       oPWRITE;
  logic [AW-1:0]              oPADDR;
  logic [DW-1:0]              oPWDATA;
  logic [DW-1:0]              iPRDATA;
  logic                       iPREADY;
  logic [NUM_MST-1:0]         oGrant;

  modport slave (
    input  iPSEL, iPENABLE, iPWRITE, iPADDR, iPWDATA, iPRDATA, iPREADY,
    output oPRDATA, oPREADY, oPSEL, oPENABLE, oPWRITE, oPADDR, oPWDATA, oGrant
  );

  modport master (
    output iPSEL, iPENABLE, iPWRITE, iPADDR, iPWDATA, iPRDATA, iPREADY,
    input  oPRDATA, oPREADY, oPSEL, oPENABLE, oPWRITE, oPADDR, oPWDATA, oGrant
  );

endinterface

`default_nettype wire

// File: rtl/apb_master_arbiter_rr.sv
// ============================================================================
// apb_rr_arbiter : combinational round-robin pick, first requester at/after ptr
// Revision: 1.0
// ============================================================================
`default_nettype none

module apb_rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_o
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  int idx;

  // Scan farthest-to-nearest so the requester closest to ptr is written last.
  always_comb begin
    gnt_o = '0;
    idx   = 0;
    if (en_i) begin
      for (int k = N - 1; k >= 0; k--) begin
        idx = (int'(ptr_i) + k) % N;
        if (req_i[idx[IW-1:0]]) begin
          gnt_o = N'(1) << idx;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/apb_master_arbiter.sv
// ============================================================================
// apb_master_arbiter : round-robin sharing of one APB slave fabric by NUM_MST
// masters; each granted transfer is re-timed as a fresh setup/access sequence.
// Revision: 1.0
// ============================================================================
`default_nettype none

module apb_master_arbiter
  import apb_master_arbiter_pkg::*;
#(
  parameter int NUM_MST = c_DEF_NUM_MST,
  parameter int NUM_SLV = c_DEF_NUM_SLV,
  parameter int AW      = c_DEF_AW,
  parameter int DW      = c_DEF_DW
) (
  input  logic                 iClk,
  input  logic                 iRsn,
  apb_master_arbiter_if.slave  bus
);
  localparam int PW = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;

  state_t             state_q;
  logic [PW-1:0]      ptr_q;
  logic [PW-1:0]      owner_q;
  logic [NUM_MST-1:0] grant_q;
  logic [NUM_MST-1:0] pready_q;
  logic [NUM_SLV-1:0] psel_q;
  logic               penable_q;
  logic               pwrite_q;
  logic [AW-1:0]      paddr_q;
  logic [DW-1:0]      pwdata_q;
  logic [DW-1:0]      prdata_q;

  logic [NUM_MST-1:0] w_req;
  logic [NUM_MST-1:0] w_gnt;
  logic [PW-1:0]      w_gnt_idx;
  logic [NUM_SLV-1:0] w_psel;
  logic               w_pwrite;
  logic [AW-1:0]      w_paddr;
  logic [DW-1:0]      w_pwdata;
  logic [PW-1:0]      ptr_d;

  generate
    for (genvar m = 0; m < NUM_MST; m++) begin : g_req
      assign w_req[m] = |bus.iPSEL[m*NUM_SLV +: NUM_SLV];
    end
  endgenerate

  apb_rr_arbiter #(
    .N  (NUM_MST),
    .PW (PW)
  ) u_rr (
    .req_i (w_req),
    .ptr_i (ptr_q),
    .en_i  (state_q == ST_IDLE),
    .gnt_o (w_gnt)
  );

  always_comb begin
    w_gnt_idx = '0;
    w_psel    = '0;
    w_pwrite  = 1'b0;
    w_paddr   = '0;
    w_pwdata  = '0;
    for (int m = 0; m < NUM_MST; m++) begin
      if (w_gnt[m]) begin
        w_gnt_idx = PW'(m);
        w_psel    = bus.iPSEL[m*NUM_SLV +: NUM_SLV];
        w_pwrite  = bus.iPWRITE[m];
        w_paddr   = bus.iPADDR[m*AW +: AW];
        w_pwdata  = bus.iPWDATA[m*DW +: DW];
      end
    end
  end

  assign ptr_d = PW'(rr_next(32'(owner_q), NUM_MST));

  // Upstream signals are sampled only at capture; everything after that
  // comes from the captured registers, so owner-side changes are ignored.
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      grant_q   <= '0;
      pready_q  <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      prdata_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|w_gnt) begin
            owner_q  <= w_gnt_idx;
            grant_q  <= w_gnt;
            psel_q   <= w_psel;
            pwrite_q <= w_pwrite;
            paddr_q  <= w_paddr;
            pwdata_q <= w_pwdata;
            state_q  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (bus.iPREADY) begin
            penable_q <= 1'b0;
            psel_q    <= '0;
            prdata_q  <= bus.iPRDATA;
            pready_q  <= grant_q;
            state_q   <= ST_DONE;
          end
        end
        ST_DONE: begin
          pready_q <= '0;
          grant_q  <= '0;
          ptr_q    <= ptr_d;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.oPSEL    = psel_q;
  assign bus.oPENABLE = penable_q;
  assign bus.oPWRITE  = pwrite_q;
  assign bus.oPADDR   = paddr_q;
  assign bus.oPWDATA  = pwdata_q;
  assign bus.oPRDATA  = prdata_q;
  assign bus.oPREADY  = pready_q;
  assign bus.oGrant   = grant_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_master_arbiter.sv
// ============================================================================
// tb_apb_master_arbiter : directed bench with a completion-order scoreboard
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_apb_master_arbiter;
  import apb_master_arbiter_pkg::*;

  localparam int NUM_MST = 2;
  localparam int NUM_SLV = 4;
  localparam int AW      = 16;
  localparam int DW      = 32;

  typedef struct {
    int                 mst;
    logic               wr;
    logic [AW-1:0]      addr;
    logic [DW-1:0]      wdata;
    logic [NUM_SLV-1:0] psel;
    logic [DW-1:0]      rdata;
    int                 lat;
    int                 en_cycles;
  } exp_t;

  logic iClk = 1'b0;
  logic iRsn = 1'b0;
  always #5 iClk = ~iClk;

  apb_master_arbiter_if #(.NUM_MST(NUM_MST), .NUM_SLV(NUM_SLV), .AW(AW), .DW(DW)) bus ();

  apb_master_arbiter #(.NUM_MST(NUM_MST), .NUM_SLV(NUM_SLV), .AW(AW), .DW(DW)) dut (
    .iClk (iClk),
    .iRsn (iRsn),
    .bus  (bus)
  );

  // Slave model: memory keyed by PADDR[7:0], programmable wait states.
  logic [DW-1:0] mem [256];
  int            wait_cfg = 0;
  int            wcnt     = 0;

  function automatic logic [DW-1:0] init_val(input int i);
    return 32'h5EED_0000 | 32'(i);
  endfunction

  assign bus.iPREADY = bus.oPENABLE && (wcnt >= wait_cfg);
  assign bus.iPRDATA = mem[bus.oPADDR[7:0]];

  always @(posedge iClk) begin
    if (!iRsn) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      wcnt <= 0;
    end else begin
      if (bus.oPENABLE && !bus.iPREADY) wcnt <= wcnt + 1;
      else                              wcnt <= 0;
      if (bus.oPENABLE && bus.iPREADY && bus.oPWRITE) mem[bus.oPADDR[7:0]] <= bus.oPWDATA;
    end
  end

  int            checks = 0;
  int            errors = 0;
  int            cyc    = 0;
  int            en_cnt = 0;
  int            req_cyc [NUM_MST];
  logic [DW-1:0] shadow [256];
  exp_t          sb [$];
  exp_t          mq0 [$];
  exp_t          mq1 [$];
  exp_t          pend_x;
  logic          pend = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int m, input exp_t x);
    bus.iPSEL[m*NUM_SLV +: NUM_SLV] = x.psel;
    bus.iPWRITE[m]                  = x.wr;
    bus.iPADDR[m*AW +: AW]          = x.addr;
    bus.iPWDATA[m*DW +: DW]         = x.wdata;
    bus.iPENABLE[m]                 = 1'b0;
    req_cyc[m]                      = cyc;
  endtask

  // Expected completions are pushed in the order the arbiter must serve them.
  task automatic req(input int m, input logic wr, input logic [AW-1:0] addr,
                     input logic [DW-1:0] wdata, input logic [NUM_SLV-1:0] psel,
                     input int lat, input int enc);
    exp_t x;
    x.mst = m; x.wr = wr; x.addr = addr; x.wdata = wdata; x.psel = psel;
    x.lat = lat; x.en_cycles = enc; x.rdata = '0;
    if (wr) shadow[addr[7:0]] = wdata;
    else    x.rdata = shadow[addr[7:0]];
    sb.push_back(x);
    if (bus.iPSEL[m*NUM_SLV +: NUM_SLV] != '0) begin
      if (m == 0) mq0.push_back(x);
      else        mq1.push_back(x);
    end else begin
      load(m, x);
    end
  endtask

  task automatic monitor();
    chk("grant_onehot0", 64'($onehot0(bus.oGrant)), 64'd1);
    if (bus.oPENABLE) en_cnt++;
    if (pend) begin
      chk("pready_owner", bus.oPREADY, 64'(1) << pend_x.mst);
      chk("done_slave_idle", {bus.oPSEL, bus.oPENABLE}, 0);
      if (pend_x.lat >= 0) chk("latency", cyc - req_cyc[pend_x.mst], pend_x.lat);
      if (!pend_x.wr) chk("prdata", bus.oPRDATA, pend_x.rdata);
      pend = 1'b0;
    end else begin
      chk("pready_quiet", bus.oPREADY, 0);
    end
    if (bus.oPSEL != '0 && !bus.oPENABLE && sb.size() > 0) begin
      chk("setup_psel", bus.oPSEL, sb[0].psel);
      chk("setup_paddr", bus.oPADDR, sb[0].addr);
    end
    if (bus.oPENABLE && sb.size() > 0) chk("access_paddr", bus.oPADDR, sb[0].addr);
    if (bus.oPENABLE && bus.iPREADY) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_xfer observed=%0h expected=none", bus.oGrant);
      end
      if (sb.size() != 0) begin
        pend_x = sb.pop_front();
        pend   = 1'b1;
        chk("grant", bus.oGrant, 64'(1) << pend_x.mst);
        chk("psel", bus.oPSEL, pend_x.psel);
        chk("pwrite", bus.oPWRITE, pend_x.wr);
        if (pend_x.wr) chk("pwdata", bus.oPWDATA, pend_x.wdata);
        if (pend_x.en_cycles > 0) chk("penable_cycles", en_cnt, pend_x.en_cycles);
      end
      en_cnt = 0;
    end
  endtask

  task automatic step();
    @(negedge iClk);
    cyc++;
    monitor();
    for (int m = 0; m < NUM_MST; m++) begin
      if (bus.oPREADY[m]) begin
        if (m == 0 && mq0.size() > 0)      load(0, mq0.pop_front());
        else if (m == 1 && mq1.size() > 0) load(1, mq1.pop_front());
        else begin
          bus.iPSEL[m*NUM_SLV +: NUM_SLV] = '0;
          bus.iPENABLE[m]                 = 1'b0;
        end
      end else if (bus.iPSEL[m*NUM_SLV +: NUM_SLV] != '0) begin
        bus.iPENABLE[m] = 1'b1;
      end
    end
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while ((sb.size() != 0 || pend) && n < bound) begin
      step();
      n++;
    end
    checks++;
    assert (sb.size() == 0 && !pend) else begin
      errors++;
      $error("FAIL drain_timeout observed=%0d expected=0", sb.size());
    end
    step();
  endtask

  task automatic reset_chk();
    chk("rst_psel", bus.oPSEL, 0);
    chk("rst_penable", bus.oPENABLE, 0);
    chk("rst_pwrite", bus.oPWRITE, 0);
    chk("rst_paddr", bus.oPADDR, 0);
    chk("rst_pwdata", bus.oPWDATA, 0);
    chk("rst_prdata", bus.oPRDATA, 0);
    chk("rst_pready", bus.oPREADY, 0);
    chk("rst_grant", bus.oGrant, 0);
  endtask

  initial begin
    exp_t y;
    bus.iPSEL = '0; bus.iPENABLE = '0; bus.iPWRITE = '0;
    bus.iPADDR = '0; bus.iPWDATA = '0;
    for (int i = 0; i < 256; i++) shadow[i] = init_val(i);

    repeat (3) step();
    reset_chk();
    iRsn = 1'b1;
    step();

    // single write then read-back through master 0
    wait_cfg = 0;
    req(0, 1'b1, 16'h0010, 32'hA5A5_0001, 4'b0001, 3, 1);
    drain(40);
    chk("slv0_reg10", mem[8'h10], 32'hA5A5_0001);
    req(0, 1'b0, 16'h0010, 32'h0, 4'b0001, 3, 1);
    drain(40);

    // three wait states on a crypto-block read by master 1
    wait_cfg = 3;
    req(1, 1'b0, 16'h0008, 32'h0, 4'b1000, 6, 4);
    drain(40);
    chk("prdata_hold", bus.oPRDATA, init_val(8));

    // contention: pointer at 0, both masters keep requesting
    wait_cfg = 0;
    req(0, 1'b1, 16'h0001, 32'h0000_0A01, 4'b0001, 3, 1);
    req(1, 1'b1, 16'h0002, 32'h0000_0B01, 4'b0010, -1, 1);
    req(0, 1'b1, 16'h0003, 32'h0000_0A02, 4'b0001, -1, 1);
    req(1, 1'b0, 16'h0001, 32'h0, 4'b0010, -1, 1);
    drain(60);

    // owner changes its address mid-access while master 1 is stalled
    wait_cfg = 2;
    req(0, 1'b1, 16'h0020, 32'h1111_2222, 4'b0001, 5, 3);
    req(1, 1'b1, 16'h0030, 32'hDEAD_BEEF, 4'b0100, -1, 3);
    step();
    step();
    bus.iPADDR[0 +: AW]  = 16'h0099;
    bus.iPWDATA[0 +: DW] = 32'h0BAD_0BAD;
    drain(60);
    chk("mem_20", mem[8'h20], 32'h1111_2222);
    chk("mem_30", mem[8'h30], 32'hDEAD_BEEF);
    chk("mem_99", mem[8'h99], init_val(8'h99));

    // master 1 withdraws before being granted
    wait_cfg = 0;
    req(0, 1'b0, 16'h0030, 32'h0, 4'b0100, 3, 1);
    step();
    bus.iPSEL[NUM_SLV +: NUM_SLV] = 4'b0010;
    step();
    bus.iPSEL[NUM_SLV +: NUM_SLV] = 4'b0000;
    drain(40);
    req(1, 1'b0, 16'h0020, 32'h0, 4'b0001, 3, 1);
    req(0, 1'b1, 16'h0040, 32'h0BAD_F00D, 4'b0001, -1, 1);
    drain(60);

    // asynchronous reset in the middle of an access
    wait_cfg = 5;
    y.mst = 0; y.wr = 1'b1; y.addr = 16'h0050; y.wdata = 32'h5555_AAAA;
    y.psel = 4'b0001; y.rdata = '0; y.lat = -1; y.en_cycles = 0;
    load(0, y);
    repeat (3) step();
    chk("pre_rst_penable", bus.oPENABLE, 1);
    #2 iRsn = 1'b0;
    #1 reset_chk();
    bus.iPSEL = '0; bus.iPENABLE = '0;
    sb.delete(); mq0.delete(); mq1.delete();
    pend = 1'b0; en_cnt = 0; wait_cfg = 0;
    for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
    repeat (2) step();
    iRsn = 1'b1;
    step();
    chk("mem_50_untouched", mem[8'h50], init_val(8'h50));
    req(0, 1'b1, 16'h0060, 32'hCAFE_0006, 4'b0100, 3, 1);
    req(1, 1'b0, 16'h0060, 32'h0, 4'b0100, -1, 1);
    drain(60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
